// File: rtl/t03_wishbone_manager.sv
// Single-beat Wishbone classic manager: turns a core read/write request into one
// bus cycle, terminated by ACK_I, ERR_I or an internal timeout.
module t03_wishbone_manager #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        READ_I,
    input  logic        WRITE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] CPU_DAT_I,
    input  logic [3:0]  SEL_I,
    output logic [31:0] CPU_DAT_O,
    output logic        BUSY_O,
    output logic        ERR_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    // Last BUS cycle index that may still be waited out (TIMEOUT_CYCLES >= 1).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             fail;

    assign req  = READ_I | WRITE_I;
    assign fail = ERR_I | (cnt == CNT_LAST);

    // Gated by nrst so a request held during reset is not reported as in progress.
    assign BUSY_O = nrst & ((state == BUS) | ((state == IDLE) & req));

    // NOTE: the bus outputs are registers loaded on entry to BUS and cleared on exit,
    // so they are glitch-free and zero in IDLE/DONE without a separate output mux.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            CPU_DAT_O <= '0;
            ERR_O     <= 1'b0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            STB_O     <= 1'b0;
            CYC_O     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ERR_O <= 1'b0;
                    if (req) begin
                        ADR_O <= ADR_I;
                        DAT_O <= CPU_DAT_I;
                        SEL_O <= SEL_I;
                        WE_O  <= WRITE_I;
                        STB_O <= 1'b1;
                        CYC_O <= 1'b1;
                        cnt   <= '0;
                        state <= BUS;
                    end
                end
                BUS: begin
                    if (fail || ACK_I) begin
                        // Error and timeout both win over a simultaneous ACK_I.
                        if (!WE_O) CPU_DAT_O <= fail ? ERR_DATA : DAT_I;
                        ERR_O <= fail;
                        ADR_O <= '0;
                        DAT_O <= '0;
                        SEL_O <= '0;
                        WE_O  <= 1'b0;
                        STB_O <= 1'b0;
                        CYC_O <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ERR_O <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t03_wishbone_manager.sv
// Directed bench: one default-timeout instance for normal traffic, one with
// TIMEOUT_CYCLES=4 for the timeout scenario; both share the stimulus.
module tb_t03_wishbone_manager;

    logic        clk;
    logic        nrst;
    logic        read_i, write_i;
    logic [31:0] adr_i, cpu_dat_i, dat_i;
    logic [3:0]  sel_i;
    logic        ack_i, err_i;

    logic [31:0] cpu_dat_o, adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        busy_o, err_o, we_o, stb_o, cyc_o;

    logic [31:0] to_cpu_dat, to_adr, to_dat;
    logic [3:0]  to_sel;
    logic        to_busy, to_err, to_we, to_stb, to_cyc;

    int n_checks = 0;
    int n_errors = 0;

    t03_wishbone_manager u_dut (
        .clk(clk), .nrst(nrst),
        .READ_I(read_i), .WRITE_I(write_i), .ADR_I(adr_i), .CPU_DAT_I(cpu_dat_i), .SEL_I(sel_i),
        .CPU_DAT_O(cpu_dat_o), .BUSY_O(busy_o), .ERR_O(err_o),
        .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o),
        .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i)
    );

    t03_wishbone_manager #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .nrst(nrst),
        .READ_I(read_i), .WRITE_I(write_i), .ADR_I(adr_i), .CPU_DAT_I(cpu_dat_i), .SEL_I(sel_i),
        .CPU_DAT_O(to_cpu_dat), .BUSY_O(to_busy), .ERR_O(to_err),
        .ADR_O(to_adr), .DAT_O(to_dat), .SEL_O(to_sel), .WE_O(to_we), .STB_O(to_stb), .CYC_O(to_cyc),
        .DAT_I(dat_i), .ACK_I(ack_i), .ERR_I(err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; read_i = 1'b0; write_i = 1'b0; adr_i = '0; cpu_dat_i = '0;
        sel_i = '0; dat_i = '0; ack_i = 1'b0; err_i = 1'b0;

        #22;
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cpu_dat", cpu_dat_o, 32'd0);
        nrst = 1'b1;
        tick();

        // Minimum-latency read.
        read_i = 1'b1; adr_i = 32'h3300_0010; sel_i = 4'hF;
        #1;
        check("rd_idle_busy", 32'(busy_o), 32'd1);
        check("rd_idle_cyc", 32'(cyc_o), 32'd0);
        tick();
        check("rd_bus_cyc", 32'(cyc_o), 32'd1);
        check("rd_bus_stb", 32'(stb_o), 32'd1);
        check("rd_bus_adr", adr_o, 32'h3300_0010);
        check("rd_bus_sel", 32'(sel_o), 32'hF);
        check("rd_bus_we", 32'(we_o), 32'd0);
        read_i = 1'b0; ack_i = 1'b1; dat_i = 32'hDEAD_BEEF;
        tick();
        ack_i = 1'b0;
        check("rd_done_dat", cpu_dat_o, 32'hDEAD_BEEF);
        check("rd_done_busy", 32'(busy_o), 32'd0);
        check("rd_done_cyc", 32'(cyc_o), 32'd0);
        check("rd_done_adr", adr_o, 32'd0);
        check("rd_done_err", 32'(err_o), 32'd0);
        tick();

        // Write with four wait states; request inputs change during BUS.
        write_i = 1'b1; adr_i = 32'h0000_0100; cpu_dat_i = 32'h1234_5678; sel_i = 4'b0001;
        tick();
        write_i = 1'b0; adr_i = 32'hFFFF_FFFF; cpu_dat_i = 32'h0; sel_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("wr_bus_we", 32'(we_o), 32'd1);
            check("wr_bus_dat", dat_o, 32'h1234_5678);
            check("wr_bus_sel", 32'(sel_o), 32'd1);
            check("wr_bus_adr", adr_o, 32'h0000_0100);
            check("wr_bus_cyc", 32'(cyc_o), 32'd1);
            if (i == 4) ack_i = 1'b1;
            tick();
        end
        ack_i = 1'b0;
        check("wr_done_cpu_dat", cpu_dat_o, 32'hDEAD_BEEF);
        check("wr_done_cyc", 32'(cyc_o), 32'd0);
        check("wr_done_err", 32'(err_o), 32'd0);
        tick();

        // ACK_I and ERR_I together on a read: error wins.
        read_i = 1'b1; adr_i = 32'h0000_0044;
        tick();
        read_i = 1'b0; ack_i = 1'b1; err_i = 1'b1; dat_i = 32'h1111_1111;
        tick();
        ack_i = 1'b0; err_i = 1'b0;
        check("ae_done_err", 32'(err_o), 32'd1);
        check("ae_done_dat", cpu_dat_o, 32'hBAD0_BAD0);
        tick();
        check("ae_idle_err", 32'(err_o), 32'd0);

        // Both requests high is a write and leaves CPU_DAT_O alone.
        read_i = 1'b1; write_i = 1'b1; adr_i = 32'h0000_0080; cpu_dat_i = 32'hCAFE_0001;
        tick();
        check("rw_bus_we", 32'(we_o), 32'd1);
        read_i = 1'b0; write_i = 1'b0; ack_i = 1'b1; dat_i = 32'h2222_2222;
        tick();
        ack_i = 1'b0;
        check("rw_done_cpu_dat", cpu_dat_o, 32'hBAD0_BAD0);
        tick();

        // READ_I held through DONE: the second transaction starts from IDLE.
        read_i = 1'b1; adr_i = 32'h0000_0200;
        tick();
        ack_i = 1'b1; dat_i = 32'h0A0A_0A0A;
        tick();
        ack_i = 1'b0;
        check("hold_done_dat", cpu_dat_o, 32'h0A0A_0A0A);
        check("hold_done_busy", 32'(busy_o), 32'd0);
        check("hold_done_cyc", 32'(cyc_o), 32'd0);
        tick();
        check("hold_idle_cyc", 32'(cyc_o), 32'd0);
        check("hold_idle_busy", 32'(busy_o), 32'd1);
        tick();
        check("hold_bus2_cyc", 32'(cyc_o), 32'd1);
        read_i = 1'b0; ack_i = 1'b1; dat_i = 32'h0B0B_0B0B;
        tick();
        ack_i = 1'b0;
        check("hold_done2_dat", cpu_dat_o, 32'h0B0B_0B0B);
        tick();

        // Asynchronous reset in the middle of BUS.
        read_i = 1'b1; adr_i = 32'h0000_0300;
        tick();
        read_i = 1'b0;
        check("ar_bus_cyc", 32'(cyc_o), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("ar_cyc", 32'(cyc_o), 32'd0);
        check("ar_stb", 32'(stb_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_cpu_dat", cpu_dat_o, 32'd0);
        check("ar_adr", adr_o, 32'd0);
        #1 nrst = 1'b1;
        tick();
        read_i = 1'b1; adr_i = 32'h0000_0304;
        tick();
        check("ar_rd_adr", adr_o, 32'h0000_0304);
        read_i = 1'b0; ack_i = 1'b1; dat_i = 32'h5555_AAAA;
        tick();
        ack_i = 1'b0;
        check("ar_rd_dat", cpu_dat_o, 32'h5555_AAAA);
        check("ar_rd_err", 32'(err_o), 32'd0);
        tick();

        // Timeout on the TIMEOUT_CYCLES=4 instance; start from a clean reset.
        #1 nrst = 1'b0;
        #2 nrst = 1'b1;
        tick();
        read_i = 1'b1; adr_i = 32'h0000_0400;
        tick();
        read_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_bus_cyc", 32'(to_cyc), 32'd1);
            check("to_bus_err", 32'(to_err), 32'd0);
            tick();
        end
        check("to_done_cyc", 32'(to_cyc), 32'd0);
        check("to_done_err", 32'(to_err), 32'd1);
        check("to_done_dat", to_cpu_dat, 32'hBAD0_BAD0);
        tick();
        check("to_idle_err", 32'(to_err), 32'd0);
        check("to_idle_cyc", 32'(to_cyc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/t03_wishbone_manager.md
T03_WISHBONE_MANAGER -- requirements
Module: t03_wishbone_manager

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of cycles the block waits for ACK_I or ERR_I before aborting a cycle.
REQ-002 Parameter ERR_DATA, default 32'hBAD0_BAD0, is the value returned on CPU_DAT_O for an aborted or errored read.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 READ_I  input  1  read request from the core request unit.
REQ-006 WRITE_I  input  1  write request from the core request unit.
REQ-007 ADR_I  input  32  request address.
REQ-008 CPU_DAT_I  input  32  write data.
REQ-009 SEL_I  input  4  byte lane select.
REQ-010 CPU_DAT_O  output  32  read data returned to the core.
REQ-011 BUSY_O  output  1  transaction in progress; the core must hold its request stable while high.
REQ-012 ERR_O  output  1  one-cycle pulse: the completed transaction failed (ERR_I or timeout).
REQ-013 ADR_O, DAT_O  output  32 each  Wishbone address and write data.
REQ-014 SEL_O  output  4  Wishbone byte select.
REQ-015 WE_O, STB_O, CYC_O  output  1 each  Wishbone write enable, strobe, cycle.
REQ-016 DAT_I  input  32  Wishbone read data.
REQ-017 ACK_I, ERR_I  input  1 each  Wishbone acknowledge and error terminations.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS (cycle active), DONE (one-cycle completion).
REQ-019 In IDLE, READ_I or WRITE_I high SHALL register ADR_I, CPU_DAT_I, SEL_I, and WE (1 if WRITE_I), clear the timeout counter, and move to BUS.
REQ-020 READ_I and WRITE_I both high SHALL be treated as a write.
REQ-021 BUSY_O SHALL be combinational: high in BUS; high in IDLE whenever READ_I or WRITE_I is high; low in DONE and in IDLE with no request.
REQ-022 In BUS, CYC_O and STB_O SHALL be high, and ADR_O, DAT_O, SEL_O, WE_O SHALL present the registered values; all four are zero outside BUS.
REQ-023 In BUS with ACK_I high, the block SHALL go to DONE and, for a read, load CPU_DAT_O from DAT_I on that edge.
REQ-024 In BUS with ERR_I high, the block SHALL go to DONE with ERR_O high in DONE and, for a read, load CPU_DAT_O with ERR_DATA; ERR_I takes priority over a simultaneous ACK_I.
REQ-025 The 8-bit-minimum timeout counter SHALL increment each BUS cycle without a termination; on reaching TIMEOUT_CYCLES it SHALL behave as ERR_I.
REQ-026 Minimum latency is request seen in cycle N, BUS in N+1, ACK_I in N+1, DONE in N+2 (BUSY_O low), IDLE in N+3.
REQ-027 DONE SHALL return to IDLE unconditionally; requests present in DONE are ignored.
REQ-028 CPU_DAT_O SHALL hold the last read result until the next read completes; writes leave it unchanged.
REQ-029 ERR_O SHALL be high only in DONE following an error or timeout termination.
REQ-030 Request inputs changing during BUS SHALL have no effect on the Wishbone outputs.

Reset
REQ-031 nrst low SHALL immediately force IDLE, clear the counter, set CPU_DAT_O, ADR_O, DAT_O, SEL_O to 0, and set WE_O, STB_O, CYC_O, ERR_O to 0, including mid-cycle in BUS.
REQ-032 After nrst rises, the first request SHALL be accepted on the first rising edge with the request present.

Verification
REQ-033 Read ADR_I=0x3300_0010, SEL_I=4'hF, ACK_I one cycle after STB_O with DAT_I=0xDEAD_BEEF -> CPU_DAT_O=0xDEAD_BEEF in DONE, BUSY_O low in DONE, total 3 cycles back to IDLE.
REQ-034 Write ADR_I=0x0000_0100, CPU_DAT_I=0x1234_5678, SEL_I=4'b0001, ACK_I after 4 wait cycles -> WE_O=1, DAT_O=0x1234_5678, SEL_O=1 held 5 cycles, CPU_DAT_O unchanged.
REQ-035 Read with no ACK_I and TIMEOUT_CYCLES=4 -> CYC_O drops after 4 BUS cycles, ERR_O pulses once, CPU_DAT_O=0xBAD0_BAD0.
REQ-036 ACK_I and ERR_I high together on a read -> ERR_O=1, CPU_DAT_O=ERR_DATA.
REQ-037 nrst low during BUS -> CYC_O, STB_O, BUSY_O low without a clock edge; the next read completes normally.
REQ-038 READ_I=WRITE_I=1 -> WE_O=1 throughout; READ_I held through DONE -> a second transaction starts from IDLE, not from DONE.
